// File: rtl/apb_master_bridge.sv
// Valid/ready command interface to APB3 master, one transfer outstanding at a time.
// Define APB_TIMEOUT_EN to abort ACCESS phases that stall longer than TIMEOUT_CYCLES.
module apb_master_bridge #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t state;
    state_t state_next;
    logic   accept;
    logic   complete;
    logic   timeout_hit;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("apb_master_bridge: TIMEOUT_CYCLES must be in 1..65535");
    end

    assign accept   = (state == IDLE) && cmd_valid;
    assign complete = (state == ACCESS) && PREADY;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge PCLK) begin
        if (!PRESETn || state == SETUP) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !PREADY) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Fires on the stalled edge that would bring the count to TIMEOUT_CYCLES;
    // a PREADY=1 on that same edge is a normal completion instead.
    assign timeout_hit = (state == ACCESS) && !PREADY &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_valid) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (complete || timeout_hit) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                PWRITE <= cmd_write;
                PADDR  <= cmd_addr;
                PWDATA <= cmd_wdata;
            end
            if (complete) begin
                rsp_rdata <= PWRITE ? '0 : PRDATA;
                rsp_err   <= PSLVERR;
            end else if (timeout_hit) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
        end
    end

    assign cmd_ready = (state == IDLE);
    assign PSEL      = (state == SETUP) || (state == ACCESS);
    assign PENABLE   = (state == ACCESS);
    assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: driver + APB slave model feed
// expectation queues; independent APB and response monitors compare.
module tb_apb_master_bridge;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int TO     = 16;
`ifdef APB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              PCLK = 1'b0;
    logic              PRESETn;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [DATA_W-1:0] rsp_rdata;
    logic              PSEL, PENABLE, PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA, PRDATA;
    logic              PREADY, PSLVERR;

    apb_master_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    typedef struct { logic [31:0] rdata; logic err; int lat; int accept; } rsp_t;
    typedef struct { logic write; logic [31:0] addr; logic [31:0] wdata; int access; } apb_t;
    typedef struct { int waits; logic err; } plan_t;

    rsp_t  rsp_q[$];
    apb_t  apb_q[$];
    plan_t plan_q[$];
    logic [31:0] model_mem [logic [31:0]];
    logic [31:0] slave_mem [logic [31:0]];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    // APB slave: random wait states and error from the per-transfer plan,
    // random noise on PRDATA/PSLVERR/PREADY whenever they must be ignored.
    initial begin : slave
        int cnt;
        plan_t p;
        PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
        cnt = 1000; p.waits = 0; p.err = 1'b0;
        forever begin
            @(posedge PCLK); #1;
            PREADY  = 1'($urandom_range(0, 1));
            PRDATA  = $urandom;
            PSLVERR = 1'($urandom_range(0, 1));
            if (PSEL && !PENABLE) begin
                if (plan_q.size() > 0) begin
                    p = plan_q.pop_front();
                    cnt = p.waits;
                end else begin
                    cnt = 1000;
                end
            end else if (PSEL && PENABLE) begin
                if (cnt == 0) begin
                    PREADY  = 1'b1;
                    PSLVERR = p.err;
                    if (PWRITE) slave_mem[PADDR] = PWDATA;
                    else PRDATA = slave_mem.exists(PADDR) ? slave_mem[PADDR] : dflt(PADDR);
                end else begin
                    PREADY = 1'b0;
                    cnt--;
                end
            end
        end
    end

    // APB protocol monitor: checks phase sequencing, stable address/data and ACCESS length.
    initial begin : apb_mon
        apb_t e;
        bit   have;
        int   run;
        have = 0; run = 0;
        e.write = 0; e.addr = 0; e.wdata = 0; e.access = -1;
        forever begin
            @(negedge PCLK);
            if (PENABLE && !PSEL) check("penable_without_psel", PENABLE, 0);
            if (PSEL && !PENABLE) begin
                check("setup_expected", (apb_q.size() > 0) ? 1 : 0, 1);
                if (apb_q.size() > 0) begin
                    e = apb_q.pop_front();
                    have = 1;
                    run = 0;
                    check("setup_pwrite", PWRITE, e.write);
                    check("setup_paddr", PADDR, e.addr);
                    if (e.write) check("setup_pwdata", PWDATA, e.wdata);
                end
            end else if (PSEL && PENABLE && have) begin
                run++;
                check("access_pwrite", PWRITE, e.write);
                check("access_paddr", PADDR, e.addr);
                if (e.write) check("access_pwdata", PWDATA, e.wdata);
            end else if (!PSEL && have) begin
                if (e.access >= 0) check("penable_cycles", run, e.access);
                have = 0;
            end
        end
    end

    // Response monitor: pops the scoreboard on each new response.
    initial begin : rsp_mon
        rsp_t        e;
        bit          prev_v;
        logic [31:0] held_d;
        logic        held_e;
        prev_v = 0; held_d = 0; held_e = 0;
        forever begin
            @(negedge PCLK);
            if (rsp_valid) begin
                check("cmd_ready_in_resp", cmd_ready, 0);
                if (!prev_v) begin
                    check("rsp_expected", (rsp_q.size() > 0) ? 1 : 0, 1);
                    if (rsp_q.size() > 0) begin
                        e = rsp_q.pop_front();
                        check("rsp_rdata", rsp_rdata, e.rdata);
                        check("rsp_err", rsp_err, e.err);
                        check("rsp_latency", cyc - e.accept + 1, e.lat);
                    end
                    held_d = rsp_rdata;
                    held_e = rsp_err;
                end else begin
                    check("rsp_rdata_stable", rsp_rdata, held_d);
                    check("rsp_err_stable", rsp_err, held_e);
                end
            end
            prev_v = rsp_valid && !rsp_ready;
        end
    end

    task automatic garbage();
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        @(posedge PCLK); #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        n = 0;
        @(negedge PCLK);
        while (!cmd_ready && n < 50) begin
            @(negedge PCLK);
            n++;
        end
        check("cmd_ready_for_accept", cmd_ready, 1);
        @(posedge PCLK); #1;
    endtask

    // One full transfer. Expected results follow from the bridge rules:
    // latency 3 + waits, ACCESS lasts waits + 1 cycles, writes return 0;
    // with the timeout enabled, waits >= TO aborts after TO ACCESS cycles.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int waits, input logic err, input int hold, input bit probe);
        rsp_t  r;
        apb_t  a;
        plan_t p;
        bit    to;
        int    n;
        to = TO_EN && (waits >= TO);
        p.waits = waits; p.err = err;
        plan_q.push_back(p);
        a.write = wr; a.addr = addr; a.wdata = wdata; a.access = to ? TO : waits + 1;
        apb_q.push_back(a);
        r.lat = to ? 2 + TO : 3 + waits;
        r.err = to ? 1'b1 : err;
        if (wr || to) r.rdata = '0;
        else r.rdata = model_mem.exists(addr) ? model_mem[addr] : dflt(addr);
        if (wr && !to) model_mem[addr] = wdata;

        issue(wr, addr, wdata);
        r.accept = cyc;
        rsp_q.push_back(r);
        garbage();
        if (probe) begin
            repeat (100) begin
                @(posedge PCLK); #1;
                garbage();
            end
            @(negedge PCLK);
            check("stuck_penable_after_100", PENABLE, !TO_EN);
            check("stuck_rsp_valid_after_100", rsp_valid, TO_EN);
        end
        n = 0;
        @(negedge PCLK);
        while (!rsp_valid && n < 400) begin
            @(posedge PCLK); #1;
            garbage();
            @(negedge PCLK);
            n++;
        end
        check("rsp_arrives", rsp_valid, 1);
        repeat (hold) begin
            @(posedge PCLK); #1;
            garbage();
        end
        @(posedge PCLK); #1;
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge PCLK); #1;
        rsp_ready = 1'b0;
    endtask

    // Reset asserted while a read sits in ACCESS: no response may follow.
    task automatic reset_abort();
        plan_t p;
        apb_t  a;
        p.waits = 20; p.err = 1'b0;
        plan_q.push_back(p);
        a.write = 1'b0; a.addr = 32'h0000_0020; a.wdata = '0; a.access = -1;
        apb_q.push_back(a);
        issue(1'b0, 32'h0000_0020, 32'h0);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        check("abort_in_access", PENABLE, 1);
        @(posedge PCLK); #1;
        PRESETn = 1'b0;
        @(posedge PCLK);
        @(negedge PCLK);
        check("abort_psel", PSEL, 0);
        check("abort_penable", PENABLE, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_cmd_ready", cmd_ready, 1);
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        repeat (4) @(negedge PCLK);
        check("abort_no_rsp", rsp_valid, 0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin : main
        PRESETn = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_psel", PSEL, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_paddr", PADDR, 0);
        check("reset_rsp_rdata", rsp_rdata, 0);
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(negedge PCLK);
        check("post_reset_cmd_ready", cmd_ready, 1);
        check("post_reset_psel", PSEL, 0);
        check("post_reset_penable", PENABLE, 0);
        check("post_reset_rsp_valid", rsp_valid, 0);

        run_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b0, 0, 0);
        run_txn(1'b0, 32'h0000_0010, $urandom, 0, 1'b0, 0, 0);
        run_txn(1'b0, 32'h0000_0014, $urandom, 4, 1'b1, 0, 0);
        run_txn(1'b0, 32'h0000_0010, $urandom, 2, 1'b0, 5, 0);
        reset_abort();
        run_txn(1'b0, 32'h0000_0010, $urandom, 1, 1'b0, 1, 0);
        run_txn(1'b1, 32'h0000_0018, $urandom, TO - 1, 1'b0, 1, 0);
        run_txn(1'b0, 32'h0000_0018, $urandom, TO - 1, 1'b0, 0, 0);
        run_txn(1'b1, 32'h0000_001C, $urandom, TO, 1'b0, 0, 0);
        run_txn(1'b0, 32'h0000_001C, $urandom, 0, 1'b0, 0, 0);
        run_txn(1'b0, 32'h0000_0024, $urandom, 110, 1'b0, 2, 1);

        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom_range(0, 1)), 32'h0000_0010 + 32'($urandom_range(0, 7)) * 4,
                    $urandom, int'($urandom_range(0, 5)), ($urandom_range(0, 3) == 0),
                    int'($urandom_range(0, 3)), 0);
        end

        repeat (5) @(negedge PCLK);
        check("rsp_q_drained", rsp_q.size(), 0);
        check("apb_q_drained", apb_q.size(), 0);
        check("plan_q_drained", plan_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
